// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
package id_hazard_ctrl_pkg;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] NEED_NONE = 2'd0;
  localparam logic [1:0] NEED_ONE  = 2'd1;
  localparam logic [1:0] NEED_TWO  = 2'd2;

endpackage

// File: rtl/id_hazard_ctrl_reg_match.sv
// Source/destination register comparator: hits when a used, nonzero source
// matches a destination that is actually being written.
module reg_match
  import id_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       use_i,
  input  logic [4:0] dst_i,
  input  logic       wr_i,
  output logic       hit_o
);

  assign hit_o = wr_i & use_i & (src_i != REG_ZERO) & (src_i == dst_i);

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: RAW stalls against EXE/MEM writers, branch
// flushes from EXE, and saturating stall/flush statistics.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter bit          FORWARDING = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             e_wreg,
  input  logic             e_m2reg,
  input  logic             e_regrt,
  input  logic [4:0]       e_rt,
  input  logic [4:0]       e_rd,
  input  logic             e_branch_taken,
  input  logic             m_wreg,
  input  logic [4:0]       m_dst,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output state_t           dbg_state_o,
  output logic             dbg_left_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             left_q, left_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc, flush_inc;

  logic [4:0] e_dst;
  logic       e_rs_hit, e_rt_hit, m_rs_hit, m_rt_hit;
  logic       e_hit, m_hit;
  logic [1:0] need;

  assign e_dst = e_regrt ? e_rt : e_rd;

  reg_match u_e_rs (.src_i(id_rs), .use_i(id_use_rs), .dst_i(e_dst), .wr_i(e_wreg), .hit_o(e_rs_hit));
  reg_match u_e_rt (.src_i(id_rt), .use_i(id_use_rt), .dst_i(e_dst), .wr_i(e_wreg), .hit_o(e_rt_hit));
  reg_match u_m_rs (.src_i(id_rs), .use_i(id_use_rs), .dst_i(m_dst), .wr_i(m_wreg), .hit_o(m_rs_hit));
  reg_match u_m_rt (.src_i(id_rt), .use_i(id_use_rt), .dst_i(m_dst), .wr_i(m_wreg), .hit_o(m_rt_hit));

  assign e_hit = e_rs_hit | e_rt_hit;
  assign m_hit = m_rs_hit | m_rt_hit;

  // With forwarding only a load in EXE cannot be bypassed; without it an EXE
  // writer costs two cycles (until it reaches WB) and a MEM writer one.
  always_comb begin
    need = NEED_NONE;
    if (FORWARDING) begin
      if (e_m2reg && e_hit) need = NEED_ONE;
    end else begin
      if (e_hit)      need = NEED_TWO;
      else if (m_hit) need = NEED_ONE;
    end
  end

  always_comb begin
    state_d       = state_q;
    left_d        = left_q;
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (e_branch_taken) begin
      // Wrong-path instruction in ID: any pending stall is dropped.
      if_id_flush   = 1'b1;
      id_exe_bubble = 1'b1;
      flush_inc     = 1'b1;
      state_d       = S_RUN;
      left_d        = 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (need != NEED_NONE) begin
            pc_we         = 1'b0;
            if_id_we      = 1'b0;
            id_exe_bubble = 1'b1;
            stall_inc     = 1'b1;
            if (need == NEED_TWO) begin
              state_d = S_STALL;
              left_d  = 1'b1;
            end
          end
        end
        S_STALL: begin
          pc_we         = 1'b0;
          if_id_we      = 1'b0;
          id_exe_bubble = 1'b1;
          stall_inc     = 1'b1;
          state_d       = S_RUN;
          left_d        = 1'b0;
        end
        default: begin
          state_d = S_RUN;
          left_d  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (flush_inc && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      left_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign dbg_state_o = state_q;
  assign dbg_left_o  = left_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: three configurations share one stimulus stream and
// are each checked every cycle against a cycle-count model, plus literal pins.
module tb_id_hazard_ctrl;
  import id_hazard_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, e_rt, e_rd, m_dst;
  logic       id_use_rs, id_use_rt, e_wreg, e_m2reg, e_regrt, e_branch_taken, m_wreg;

  logic        pc_we_a[3], if_id_we_a[3], flush_a[3], bubble_a[3], left_a[3];
  state_t      st_a[3];
  logic [15:0] sc_a[3], fc_a[3];
  logic [15:0] sc_fw, fc_fw, sc_nf, fc_nf;
  logic [3:0]  sc_sat, fc_sat;

  int total = 0;
  int bad   = 0;

  // 0: forwarding, 16-bit; 1: no forwarding, 16-bit; 2: no forwarding, 4-bit
  int fw_cfg[3]  = '{1, 0, 0};
  int max_cfg[3] = '{65535, 65535, 15};
  int extra[3];
  int m_sc[3];
  int m_fc[3];

  id_hazard_ctrl #(.FORWARDING(1'b1), .CNT_W(16)) u_fw (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_regrt(e_regrt),
    .e_rt(e_rt), .e_rd(e_rd), .e_branch_taken(e_branch_taken), .m_wreg(m_wreg),
    .m_dst(m_dst), .pc_we(pc_we_a[0]), .if_id_we(if_id_we_a[0]), .if_id_flush(flush_a[0]),
    .id_exe_bubble(bubble_a[0]), .stall_cnt(sc_fw), .flush_cnt(fc_fw),
    .dbg_state_o(st_a[0]), .dbg_left_o(left_a[0]));

  id_hazard_ctrl #(.FORWARDING(1'b0), .CNT_W(16)) u_nf (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_regrt(e_regrt),
    .e_rt(e_rt), .e_rd(e_rd), .e_branch_taken(e_branch_taken), .m_wreg(m_wreg),
    .m_dst(m_dst), .pc_we(pc_we_a[1]), .if_id_we(if_id_we_a[1]), .if_id_flush(flush_a[1]),
    .id_exe_bubble(bubble_a[1]), .stall_cnt(sc_nf), .flush_cnt(fc_nf),
    .dbg_state_o(st_a[1]), .dbg_left_o(left_a[1]));

  id_hazard_ctrl #(.FORWARDING(1'b0), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_regrt(e_regrt),
    .e_rt(e_rt), .e_rd(e_rd), .e_branch_taken(e_branch_taken), .m_wreg(m_wreg),
    .m_dst(m_dst), .pc_we(pc_we_a[2]), .if_id_we(if_id_we_a[2]), .if_id_flush(flush_a[2]),
    .id_exe_bubble(bubble_a[2]), .stall_cnt(sc_sat), .flush_cnt(fc_sat),
    .dbg_state_o(st_a[2]), .dbg_left_o(left_a[2]));

  assign sc_a[0] = sc_fw;
  assign fc_a[0] = fc_fw;
  assign sc_a[1] = sc_nf;
  assign fc_a[1] = fc_nf;
  assign sc_a[2] = {12'd0, sc_sat};
  assign fc_a[2] = {12'd0, fc_sat};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // model
  function automatic bit reads(input logic [4:0] src, input logic use_b, input logic [4:0] dst);
    return use_b && (src != 5'd0) && (src == dst);
  endfunction

  function automatic int stalls_needed(input int fw);
    logic [4:0] ed;
    bit eh, mh;
    ed = e_regrt ? e_rt : e_rd;
    eh = reads(id_rs, id_use_rs, ed) || reads(id_rt, id_use_rt, ed);
    mh = reads(id_rs, id_use_rs, m_dst) || reads(id_rt, id_use_rt, m_dst);
    if (fw != 0) return (e_wreg && e_m2reg && eh) ? 1 : 0;
    if (e_wreg && eh) return 2;
    if (m_wreg && mh) return 1;
    return 0;
  endfunction

  // scoreboard: compare every negedge, then advance the model to the next edge
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        extra[i] = 0;
        m_sc[i]  = 0;
        m_fc[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int  n;
        bit  stall, fl;
        n     = stalls_needed(fw_cfg[i]);
        fl    = e_branch_taken;
        stall = !fl && (extra[i] > 0 || n > 0);
        check($sformatf("u%0d pc_we", i), int'(pc_we_a[i]), (stall ? 0 : 1));
        check($sformatf("u%0d if_id_we", i), int'(if_id_we_a[i]), (stall ? 0 : 1));
        check($sformatf("u%0d if_id_flush", i), int'(flush_a[i]), (fl ? 1 : 0));
        check($sformatf("u%0d bubble", i), int'(bubble_a[i]), ((stall || fl) ? 1 : 0));
        check($sformatf("u%0d stall_cnt", i), int'(sc_a[i]), m_sc[i]);
        check($sformatf("u%0d flush_cnt", i), int'(fc_a[i]), m_fc[i]);
        check($sformatf("u%0d state", i), int'(st_a[i] == S_STALL), ((extra[i] > 0) ? 1 : 0));
        check($sformatf("u%0d left", i), int'(left_a[i]), extra[i]);
        if (fl) begin
          extra[i] = 0;
          if (m_fc[i] < max_cfg[i]) m_fc[i]++;
        end else if (stall) begin
          extra[i] = (extra[i] > 0) ? extra[i] - 1 : n - 1;
          if (m_sc[i] < max_cfg[i]) m_sc[i]++;
        end
      end
    end
  end

  // driver tasks
  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    e_wreg = 1'b0; e_m2reg = 1'b0; e_regrt = 1'b0; e_rt = 5'd0; e_rd = 5'd0;
    e_branch_taken = 1'b0; m_wreg = 1'b0; m_dst = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drive_exe_add7();
    set_idle();
    e_wreg = 1'b1; e_regrt = 1'b0; e_rd = 5'd7;
    id_rt = 5'd7; id_use_rt = 1'b1;
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst u%0d pc_we", i), int'(pc_we_a[i]), 1);
      check($sformatf("rst u%0d if_id_we", i), int'(if_id_we_a[i]), 1);
      check($sformatf("rst u%0d flush", i), int'(flush_a[i]), 0);
      check($sformatf("rst u%0d bubble", i), int'(bubble_a[i]), 0);
      check($sformatf("rst u%0d stall_cnt", i), int'(sc_a[i]), 0);
      check($sformatf("rst u%0d state", i), int'(st_a[i]), int'(S_RUN));
    end
    tick();
    rst_n = 1'b1;

    // load-use with forwarding: one stall
    e_wreg = 1'b1; e_m2reg = 1'b1; e_regrt = 1'b1; e_rt = 5'd5;
    id_rs = 5'd5; id_use_rs = 1'b1;
    #1;
    check("t1 pc_we stall", int'(pc_we_a[0]), 0);
    check("t1 bubble", int'(bubble_a[0]), 1);
    tick();
    e_wreg = 1'b0; e_m2reg = 1'b0; m_wreg = 1'b1; m_dst = 5'd5;
    #1;
    check("t1 pc_we resume", int'(pc_we_a[0]), 1);
    check("t1 stall_cnt", int'(sc_a[0]), 1);
    set_idle();
    tick(); tick();
    check("t1 stall_cnt hold", int'(sc_a[0]), 1);

    // EXE writer without forwarding: two stalls through STALL state
    do_reset();
    drive_exe_add7();
    #1;
    check("t2 pc_we c1", int'(pc_we_a[1]), 0);
    check("t2 state c1", int'(st_a[1]), int'(S_RUN));
    tick();
    e_wreg = 1'b0; m_wreg = 1'b1; m_dst = 5'd7;
    #1;
    check("t2 pc_we c2", int'(pc_we_a[1]), 0);
    check("t2 state c2", int'(st_a[1]), int'(S_STALL));
    tick();
    m_wreg = 1'b0;
    #1;
    check("t2 pc_we c3", int'(pc_we_a[1]), 1);
    check("t2 state c3", int'(st_a[1]), int'(S_RUN));
    check("t2 stall_cnt", int'(sc_a[1]), 2);

    // $0 never matches; MEM writer gives one stall
    do_reset();
    e_wreg = 1'b1; e_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #1;
    check("t3 r0 no stall", int'(pc_we_a[1]), 1);
    tick();
    e_wreg = 1'b0; m_wreg = 1'b1; m_dst = 5'd3; id_rs = 5'd3;
    #1;
    check("t3 mem stall", int'(pc_we_a[1]), 0);
    tick();
    m_wreg = 1'b0;
    #1;
    check("t3 resume", int'(pc_we_a[1]), 1);
    check("t3 stall_cnt", int'(sc_a[1]), 1);

    // branch taken while in STALL
    do_reset();
    drive_exe_add7();
    tick();
    e_branch_taken = 1'b1;
    #1;
    check("t4 in stall", int'(st_a[1]), int'(S_STALL));
    check("t4 flush", int'(flush_a[1]), 1);
    check("t4 bubble", int'(bubble_a[1]), 1);
    check("t4 pc_we", int'(pc_we_a[1]), 1);
    check("t4 if_id_we", int'(if_id_we_a[1]), 1);
    tick();
    set_idle();
    #1;
    check("t4 state", int'(st_a[1]), int'(S_RUN));
    check("t4 flush_cnt", int'(fc_a[1]), 1);
    check("t4 stall_cnt", int'(sc_a[1]), 1);

    // saturation then async reset mid-stall
    do_reset();
    e_wreg = 1'b1; e_rd = 5'd9; id_rs = 5'd9; id_use_rs = 1'b1;
    repeat (21) tick();
    #1;
    check("t5 sat stall_cnt", int'(sc_a[2]), 15);
    check("t5 wide stall_cnt", int'(sc_a[1]), 21);
    check("t5 in stall", int'(st_a[2]), int'(S_STALL));
    #1;
    rst_n = 1'b0;
    #1;
    check("t5 rst stall_cnt", int'(sc_a[2]), 0);
    check("t5 rst flush_cnt", int'(fc_a[2]), 0);
    check("t5 rst state", int'(st_a[2]), int'(S_RUN));
    set_idle();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
